instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have these parameters:
- XLEN, 32, address/instruction width.
- DEPTH, 4, queue entries; a power of two, at least 2.
- RESET_PC, 0, first fetch address after reset; word-aligned.

REQ-002 The block SHALL have these ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- imem_req_o  out  1  fetch request this cycle.
- imem_addr_o  out  XLEN  fetch address, word-aligned.
- imem_rdata_i  in  XLEN  instruction for the request issued in the previous cycle (fixed 1-cycle latency).
- redirect_i  in  1  branch/jump/jr taken; flush and refetch.
- redirect_pc_i  in  XLEN  target PC; bits [1:0] are ignored and treated as 0.
- instr_valid_o  out  1  queue head holds a valid instruction.
- instr_ready_i  in  1  consumer accepts the head this cycle.
- instr_o  out  XLEN  head instruction.
- instr_pc_o  out  XLEN  head PC.
- instr_pc4_o  out  XLEN  head PC+4, modulo 2^XLEN (link value).
- count_o  out  clog2(DEPTH+1)  valid entries.

Function
REQ-003 The block SHALL hold a circular FIFO of DEPTH entries; each entry is {instr, pc}.
REQ-004 The block SHALL keep a registered fetch_pc, a pending bit and a registered pending_pc.
- pending = a request was issued last cycle.
- pending_pc = the address of that request.
REQ-005 pop SHALL be instr_valid_o AND instr_ready_i AND NOT redirect_i.
REQ-006 imem_req_o SHALL be 1 iff redirect_i = 0 and (count + pending - pop) < DEPTH.
REQ-007 The requirement in REQ-006 allows sustained 1 instr/cycle with DEPTH = 2; the combinational path instr_ready_i -> imem_req_o is permitted.
REQ-008 imem_addr_o SHALL equal fetch_pc.
REQ-009 On an issued request, fetch_pc SHALL advance by 4 modulo 2^XLEN (0xFFFFFFFC -> 0x00000000).
REQ-010 When pending = 1 and redirect_i = 0, the block SHALL push {imem_rdata_i, pending_pc} at the tail in that cycle.
REQ-011 A pushed entry SHALL appear at the head no earlier than the next cycle; there is no bypass.
REQ-012 Fetch-to-output latency SHALL be 2 cycles: request in cycle t, data in t+1, instr_valid_o in t+2 if the queue was empty.
REQ-013 When push and pop occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance; this is legal when full or when count = 1.
REQ-014 The block SHALL never push into a full queue; the rule in REQ-006 guarantees it.
REQ-015 Violating REQ-014 is a design error; the bench SHALL check count <= DEPTH every cycle.
REQ-016 When empty, instr_valid_o SHALL be 0. instr_o, instr_pc_o and instr_pc4_o SHALL then hold the value at the read pointer (don't-care to the consumer).
REQ-017 On redirect_i = 1 in cycle t, the block SHALL:
- clear count and both pointers;
- discard the response arriving in t;
- drive imem_req_o = 0 in t;
- load fetch_pc with {redirect_pc_i[XLEN-1:2], 2'b00};
- clear pending.
REQ-018 The first request at the target SHALL issue in t+1, and the target instruction SHALL be valid at the head in t+3.
REQ-019 Redirect SHALL win over a simultaneous pop and push; instr_ready_i is ignored in that cycle.
REQ-020 Back-to-back redirects SHALL each restart fetch; only the last target is fetched.
REQ-021 count_o SHALL equal the current number of valid entries.

Reset
REQ-022 While rst_i = 1, asynchronously:
- fetch_pc = RESET_PC; pending = 0;
- pointers = 0; count_o = 0;
- instr_valid_o = 0; imem_req_o = 0;
- imem_addr_o = RESET_PC.
REQ-023 instr_o, instr_pc_o and instr_pc4_o SHALL reset to 0 (entry storage cleared).
REQ-024 In the first cycle after rst_i deasserts, imem_req_o SHALL be 1 with imem_addr_o = RESET_PC.
REQ-025 Reset asserted mid-operation SHALL drop all queued and in-flight instructions; no response SHALL be pushed after reset.

Verification
REQ-026 Reset release, instr_ready_i = 1, imem_rdata_i = address:
- requests 0x0, 0x4, 0x8 in consecutive cycles;
- instr_valid_o rises 2 cycles after the first request;
- then one instruction per cycle; instr_pc4_o = instr_pc_o + 4.
REQ-027 instr_ready_i = 0 from reset, DEPTH = 4:
- exactly 4 requests issue (0x0 to 0xC), then imem_req_o = 0 with count_o = 4;
- asserting instr_ready_i for one cycle yields one pop and one new request at 0x10.
REQ-028 Redirect to 0x00000103 while full with a response pending:
- count_o = 0 the next cycle; the stale response is not pushed;
- the next request is at 0x100; instr_pc_o = 0x100 valid 3 cycles after the redirect.
REQ-029 Redirect to 0xFFFFFFF8, free-running consumer:
- the fetch sequence is 0xFFFFFFF8, 0xFFFFFFFC, 0x0;
- the entry with instr_pc_o = 0xFFFFFFFC shows instr_pc4_o = 0x0.
REQ-030 Random instr_ready_i and redirects over 10k cycles against a reference queue model:
- the in-order PC sequence between redirects matches the model;
- count_o never exceeds DEPTH; rst_i pulsed mid-run restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit with a DEPTH-entry prefetch FIFO, fixed 1-cycle imem
// latency, redirect flush and credit-style request throttling.
module instr_fetch_queue #(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  output logic                         imem_req_o,
  output logic [XLEN-1:0]              imem_addr_o,
  input  logic [XLEN-1:0]              imem_rdata_i,
  input  logic                         redirect_i,
  input  logic [XLEN-1:0]              redirect_pc_i,
  output logic                         instr_valid_o,
  input  logic                         instr_ready_i,
  output logic [XLEN-1:0]              instr_o,
  output logic [XLEN-1:0]              instr_pc_o,
  output logic [XLEN-1:0]              instr_pc4_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [AW-1:0]     r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [XLEN-1:0]   r_fetch_pc;
  logic              r_pending;
  logic [XLEN-1:0]   r_pending_pc;

  logic              w_pop, w_push, w_req;
  logic [OW-1:0]     w_occ;
  logic [XLEN-1:0]   w_redir_pc;

  assign instr_valid_o = (r_count != '0);
  assign w_pop         = instr_valid_o & instr_ready_i & ~redirect_i;
  assign w_push        = r_pending & ~redirect_i;
  // Occupancy including the in-flight response; the pop this cycle frees a
  // slot early so DEPTH=2 still sustains one instruction per cycle.
  assign w_occ         = {1'b0, r_count} + OW'(r_pending) - OW'(w_pop);
  assign w_req         = ~rst_i & ~redirect_i & (w_occ < OW'(DEPTH));
  assign w_redir_pc    = redirect_pc_i & ~(XLEN'(3));

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_fetch_pc;
  assign instr_o       = r_mem[r_rd_ptr].instr;
  assign instr_pc_o    = r_mem[r_rd_ptr].pc;
  assign instr_pc4_o   = r_mem[r_rd_ptr].pc4;
  assign count_o       = r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_pc   <= RESET_PC;
      r_pending    <= 1'b0;
      r_pending_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_fetch_pc   <= w_redir_pc;
      r_pending    <= 1'b0;
      r_pending_pc <= w_redir_pc;
    end else begin
      r_pending    <= w_req;
      r_pending_pc <= r_fetch_pc;
      if (w_req) r_fetch_pc <= r_fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Link value is stored with the entry so cleared storage reads back as zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= '{instr: imem_rdata_i,
                           pc:    r_pending_pc,
                           pc4:   r_pending_pc + XLEN'(4)};
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench: queue-level reference model predicts fetch and head order;
// a monitor compares every accepted instruction against the expected queue.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o, instr_pc_o, instr_pc4_o;
  logic [2:0]  count_o;

  instr_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_pc4_o(instr_pc4_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  // Reference model: fetch pointer, in-flight flag and occupancy as plain ints.
  logic [31:0] m_fetch, m_ppc;
  int          m_cnt, m_pending, m_pop, m_req;
  logic        last_req;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head must match the next expected entry.
  always @(negedge clk_i) begin
    if (!rst_i && instr_valid_o && instr_ready_i && !redirect_i) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("head_pc", instr_pc_o, e.pc);
        chk("head_instr", instr_o, e.instr);
        chk("head_pc4", instr_pc4_o, e.pc + 32'd4);
      end
    end
  end

  task automatic drive(input logic r, input logic d, input logic [31:0] pc);
    instr_ready_i = r;
    redirect_i    = d;
    redirect_pc_i = pc;
    imem_rdata_i  = last_req ? mem_f(last_addr) : $urandom;
    #1;
  endtask

  task automatic step();
    @(negedge clk_i);
    m_pop = (m_cnt > 0 && instr_ready_i && !redirect_i) ? 1 : 0;
    m_req = (!redirect_i && (m_cnt + m_pending - m_pop) < DEPTH) ? 1 : 0;
    chk("req", imem_req_o, m_req);
    chk("addr", imem_addr_o, m_fetch);
    chk("count", count_o, m_cnt);
    chk("valid", instr_valid_o, m_cnt > 0);
    chk("count_le_depth", count_o <= DEPTH, 1);
    last_req  = imem_req_o;
    last_addr = imem_addr_o;
    @(posedge clk_i);
    if (redirect_i) begin
      exp_q.delete();
      m_cnt = 0; m_pending = 0;
      m_fetch = redirect_pc_i & ~32'd3;
    end else begin
      if (m_pending != 0) begin
        exp_q.push_back('{pc: m_ppc, instr: mem_f(m_ppc)});
        m_cnt++;
      end
      if (m_pop != 0) m_cnt--;
      m_ppc = m_fetch;
      m_pending = m_req;
      if (m_req != 0) m_fetch = m_fetch + 32'd4;
    end
    #1;
  endtask

  task automatic cyc(input logic r, input logic d, input logic [31:0] pc);
    drive(r, d, pc);
    step();
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1; redirect_i = 1'b0; instr_ready_i = 1'b0;
    exp_q.delete();
    m_fetch = 32'h0; m_ppc = 32'h0; m_cnt = 0; m_pending = 0;
    last_req = 1'b0; last_addr = '0;
    repeat (n) begin
      @(negedge clk_i);
      chk("rst_req", imem_req_o, 0);
      chk("rst_addr", imem_addr_o, 32'h0);
      chk("rst_count", count_o, 0);
      chk("rst_valid", instr_valid_o, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_pc", instr_pc_o, 0);
      chk("rst_pc4", instr_pc4_o, 0);
      @(posedge clk_i);
    end
    #1 rst_i = 1'b0;
  endtask

  initial begin
    bit seen;
    logic r, d;
    logic [31:0] rpc;

    // Streaming from reset with an always-ready consumer.
    do_reset(2);
    drive(1, 0, 0); chk("s_addr0", imem_addr_o, 32'h0); chk("s_req0", imem_req_o, 1);
    chk("s_valid0", instr_valid_o, 0); step();
    drive(1, 0, 0); chk("s_addr1", imem_addr_o, 32'h4); chk("s_valid1", instr_valid_o, 0); step();
    drive(1, 0, 0); chk("s_addr2", imem_addr_o, 32'h8); chk("s_valid2", instr_valid_o, 1);
    chk("s_pc2", instr_pc_o, 32'h0); step();
    repeat (10) cyc(1, 0, 0);

    // Stalled consumer fills the queue, then a single pop frees one slot.
    do_reset(2);
    repeat (6) cyc(0, 0, 0);
    drive(0, 0, 0); chk("full_count", count_o, 4); chk("full_req", imem_req_o, 0); step();
    drive(1, 0, 0); chk("pop1_req", imem_req_o, 1); chk("pop1_addr", imem_addr_o, 32'h10); step();

    // Redirect with a response in flight; the stale response is dropped.
    drive(0, 1, 32'h0000_0103); chk("redir_req", imem_req_o, 0); step();
    drive(0, 0, 0); chk("redir_count", count_o, 0); chk("redir_req1", imem_req_o, 1);
    chk("redir_addr", imem_addr_o, 32'h100); step();
    cyc(0, 0, 0);
    drive(0, 0, 0); chk("redir_valid", instr_valid_o, 1); chk("redir_pc", instr_pc_o, 32'h100); step();

    // Back-to-back redirects: only the last target is fetched.
    cyc(1, 1, 32'h2000);
    cyc(0, 1, 32'h3000);
    cyc(0, 0, 0); cyc(0, 0, 0);
    drive(0, 0, 0); chk("b2b_valid", instr_valid_o, 1); chk("b2b_pc", instr_pc_o, 32'h3000); step();

    // Address wrap at the top of the address space.
    cyc(1, 1, 32'hFFFF_FFF8);
    drive(1, 0, 0); chk("wrap_a0", imem_addr_o, 32'hFFFF_FFF8); step();
    drive(1, 0, 0); chk("wrap_a1", imem_addr_o, 32'hFFFF_FFFC); step();
    drive(1, 0, 0); chk("wrap_a2", imem_addr_o, 32'h0); step();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0);
      if (instr_valid_o && instr_pc_o == 32'hFFFF_FFFC) begin
        seen = 1'b1;
        chk("wrap_pc4", instr_pc4_o, 32'h0);
      end
      step();
    end
    chk("wrap_seen", seen, 1);

    // Random consumer and redirects, with a mid-run reset.
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) do_reset(3);
      r = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 31) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      cyc(r, d, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
